// File: rtl/q_update_engine.sv
// Q-learning write-back engine. Takes an executed (state, action), its reward,
// the current Q(s,a) and max Q of the next state, and issues one Q-table write
// with Q' = Q + 2^-ALPHA_SHIFT * (R + GAMMA*Qmax_next - Q).
// Three-stage pipeline at one update per cycle. A request whose key matches an
// update still in flight is held off until that write has landed.
module q_update_engine #(
  parameter int          S_W         = 12,
  parameter int          FRAC        = 16,
  parameter logic [15:0] GAMMA       = 16'hE666,
  parameter int          ALPHA_SHIFT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           learning,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [S_W-1:0] in_state,
  input  logic [1:0]     in_action,
  input  logic [31:0]    in_reward,
  input  logic [31:0]    in_q_sa,
  input  logic [31:0]    in_q_max_next,
  output logic           wr_en,
  output logic [S_W+1:0] wr_addr,
  output logic [31:0]    wr_data,
  output logic           sat_flag,
  output logic [31:0]    upd_cnt
);

  localparam int K_W = S_W + 2;

  // FRAC only names the shared fixed-point format; the datapath never needs it,
  // but an out-of-range value still indicates a broken instantiation.
  if (ALPHA_SHIFT < 0 || ALPHA_SHIFT > 15 || FRAC < 0 || FRAC > 31) begin : g_bad_param
    $error("q_update_engine: ALPHA_SHIFT must be 0..15 and FRAC 0..31");
  end

  logic [K_W-1:0] in_key;
  logic           xfer;

  // Stage 1: discounted next-state value plus the operands carried along.
  logic                  s1_valid_q;
  logic                  s1_learn_q;
  logic [K_W-1:0]        s1_key_q;
  logic [31:0]           s1_r_q;
  logic [31:0]           s1_q_q;
  logic [31:0]           s1_gq_q;
  logic [31:0]           gq_d;

  // Stage 2: temporal difference.
  logic                  s2_valid_q;
  logic                  s2_learn_q;
  logic [K_W-1:0]        s2_key_q;
  logic [31:0]           s2_q_q;
  logic signed [33:0]    s2_td_q;
  logic [33:0]           td_d;

  // Stage 3: output registers. s3_valid_q/s3_key_q keep discarded entries
  // visible to the hazard check even though they never drive wr_en.
  logic                  s3_valid_q;
  logic [K_W-1:0]        s3_key_q;
  logic                  wr_en_q;
  logic [K_W-1:0]        wr_addr_q;
  logic [31:0]           wr_data_q;
  logic                  sat_q;
  logic [31:0]           upd_cnt_q;
  logic [31:0]           wr_data_d;
  logic                  sat_d;
  logic                  write_d;

  logic signed [48:0]    gamma_ext;
  logic signed [48:0]    qmax_ext;
  logic signed [48:0]    prod;
  logic signed [33:0]    td_sh;
  logic [34:0]           upd_w;
  logic                  unused_prod_lsbs;

  assign in_key = {in_state, in_action};

  // Hold off a request whose key is still in flight anywhere in the pipe.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_ready = 1'b1;
    if (in_valid && ((s1_valid_q && (s1_key_q == in_key)) ||
                     (s2_valid_q && (s2_key_q == in_key)) ||
                     (s3_valid_q && (s3_key_q == in_key)))) begin
      in_ready = 1'b0;
    end
  end

  assign xfer = in_valid & in_ready;

  // Stage 1 math: gq = floor(GAMMA * Qmax / 2^16), saturated to 32-bit signed.
  always_comb begin
    gamma_ext = {33'd0, GAMMA};
    qmax_ext  = {{17{in_q_max_next[31]}}, in_q_max_next};
    prod      = gamma_ext * qmax_ext;
    // Dropping the low 16 bits of a two's-complement value is a floor shift.
    if (prod[48] == prod[47]) begin
      gq_d = prod[47:16];
    end else if (prod[48]) begin
      gq_d = 32'h8000_0000;
    end else begin
      gq_d = 32'h7FFF_FFFF;
    end
  end

  assign unused_prod_lsbs = ^prod[15:0];

  // Stage 2 math: td = R + gq - Q in 34 bits, wide enough that it never wraps.
  always_comb begin
    td_d = {{2{s1_r_q[31]}}, s1_r_q} + {{2{s1_gq_q[31]}}, s1_gq_q} - {{2{s1_q_q[31]}}, s1_q_q};
  end

  // Stage 3 math: Q + floor(td / 2^ALPHA_SHIFT), clamped to 32-bit signed.
  always_comb begin
    td_sh     = s2_td_q >>> ALPHA_SHIFT;
    upd_w     = {{3{s2_q_q[31]}}, s2_q_q} + {td_sh[33], td_sh};
    wr_data_d = upd_w[31:0];
    sat_d     = 1'b0;
    if (!((upd_w[34:31] == 4'b0000) || (upd_w[34:31] == 4'b1111))) begin
      sat_d     = 1'b1;
      wr_data_d = upd_w[34] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  assign write_d = s2_valid_q & s2_learn_q;

  // Control state: stage valids, write strobe, held write port and counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      sat_q      <= 1'b0;
      upd_cnt_q  <= '0;
    end else begin
      s1_valid_q <= xfer;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      wr_en_q    <= write_d;
      sat_q      <= write_d & sat_d;
      if (write_d) begin
        wr_addr_q <= s2_key_q;
        wr_data_q <= wr_data_d;
        upd_cnt_q <= upd_cnt_q + 32'd1;
      end
    end
  end

  // Datapath payload registers, qualified by the stage valids above.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are not reset; the stage valids make stale contents harmless.
    if (xfer) begin
      s1_learn_q <= learning;
      s1_key_q   <= in_key;
      s1_r_q     <= in_reward;
      s1_q_q     <= in_q_sa;
      s1_gq_q    <= gq_d;
    end
    s2_learn_q <= s1_learn_q;
    s2_key_q   <= s1_key_q;
    s2_q_q     <= s1_q_q;
    s2_td_q    <= td_d;
    s3_key_q   <= s2_key_q;
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign sat_flag = sat_q;
  assign upd_cnt  = upd_cnt_q;

endmodule

// File: tb/tb_q_update_engine.sv
// Self-checking bench for q_update_engine: directed cases followed by random
// traffic, compared cycle by cycle against an arithmetic reference model.
module tb_q_update_engine;

  logic        clk;
  logic        rst;
  logic        learning;
  logic        in_valid;
  logic [11:0] in_state;
  logic [1:0]  in_action;
  logic [31:0] in_reward;
  logic [31:0] in_q_sa;
  logic [31:0] in_q_max_next;

  logic        in_ready,   in_ready_g;
  logic        wr_en,      wr_en_g;
  logic [13:0] wr_addr,    wr_addr_g;
  logic [31:0] wr_data,    wr_data_g;
  logic        sat_flag,   sat_g;
  logic [31:0] upd_cnt,    upd_cnt_g;

  int n_cmp = 0;
  int n_err = 0;

  localparam longint GAMMA_A = 64'd58982;   // 0xE666
  localparam int     SHIFT_A = 3;
  localparam longint GAMMA_B = 64'd32768;   // 0x8000
  localparam int     SHIFT_B = 1;
  localparam longint Q_MAX   = 64'sd2147483647;
  localparam longint Q_MIN   = -64'sd2147483648;

  q_update_engine u_dut (
    .clk(clk), .rst(rst), .learning(learning), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_action(in_action), .in_reward(in_reward), .in_q_sa(in_q_sa),
    .in_q_max_next(in_q_max_next), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sat_flag(sat_flag), .upd_cnt(upd_cnt)
  );

  q_update_engine #(.GAMMA(16'h8000), .ALPHA_SHIFT(SHIFT_B)) u_dut_g (
    .clk(clk), .rst(rst), .learning(learning), .in_valid(in_valid), .in_ready(in_ready_g),
    .in_state(in_state), .in_action(in_action), .in_reward(in_reward), .in_q_sa(in_q_sa),
    .in_q_max_next(in_q_max_next), .wr_en(wr_en_g), .wr_addr(wr_addr_g), .wr_data(wr_data_g),
    .sat_flag(sat_g), .upd_cnt(upd_cnt_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [13:0] key;
    logic        learn;
    logic [32:0] res_a;   // {sat, data} for the default instance
    logic [32:0] res_b;   // {sat, data} for the GAMMA=0x8000 instance
  } pend_t;

  pend_t       pend_q[$];
  int          cyc;
  logic [13:0] m_addr;
  logic [31:0] m_data, m_data_g;
  logic [31:0] m_cnt;

  // Reference: Q' = Q + floor((R + sat(floor(g*Qmax/2^16)) - Q) / 2^sh), clamped.
  function automatic logic [32:0] ref_update(input longint gamma, input int sh,
                                             input logic [31:0] r, input logic [31:0] q,
                                             input logic [31:0] qm);
    longint gq, td, upd;
    logic   sat;
    gq = (gamma * longint'($signed(qm))) >>> 16;
    if (gq > Q_MAX) gq = Q_MAX;
    if (gq < Q_MIN) gq = Q_MIN;
    td  = longint'($signed(r)) + gq - longint'($signed(q));
    upd = longint'($signed(q)) + (td >>> sh);
    sat = 1'b0;
    if (upd > Q_MAX) begin upd = Q_MAX; sat = 1'b1; end
    if (upd < Q_MIN) begin upd = Q_MIN; sat = 1'b1; end
    return {sat, upd[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model
  // mid-cycle, then advance the model and the clock.
  task automatic step(input logic v, input logic [11:0] s, input logic [1:0] a,
                      input logic [31:0] r, input logic [31:0] q, input logic [31:0] qm,
                      input logic learn, input logic do_rst, output logic accepted);
    pend_t p;
    logic  exp_ready, exp_en, exp_sat, exp_sat_g;
    in_valid = v; in_state = s; in_action = a; in_reward = r;
    in_q_sa = q; in_q_max_next = qm; learning = learn; rst = do_rst;
    @(negedge clk);
    exp_ready = 1'b1;
    if (v) begin
      foreach (pend_q[i]) if (pend_q[i].key == {s, a}) exp_ready = 1'b0;
    end
    exp_en = 1'b0; exp_sat = 1'b0; exp_sat_g = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      if (p.learn) begin
        exp_en    = 1'b1;
        exp_sat   = p.res_a[32];
        exp_sat_g = p.res_b[32];
        m_addr    = p.key;
        m_data    = p.res_a[31:0];
        m_data_g  = p.res_b[31:0];
        m_cnt     = m_cnt + 32'd1;
      end
    end
    check("in_ready",   64'(in_ready),   64'(exp_ready));
    check("in_ready_g", 64'(in_ready_g), 64'(exp_ready));
    check("wr_en",      64'(wr_en),      64'(exp_en));
    check("wr_en_g",    64'(wr_en_g),    64'(exp_en));
    check("wr_addr",    64'(wr_addr),    64'(m_addr));
    check("wr_data",    64'(wr_data),    64'(m_data));
    check("wr_data_g",  64'(wr_data_g),  64'(m_data_g));
    check("sat_flag",   64'(sat_flag),   64'(exp_sat));
    check("sat_flag_g", 64'(sat_g),      64'(exp_sat_g));
    check("upd_cnt",    64'(upd_cnt),    64'(m_cnt));
    accepted = v & in_ready;
    if (do_rst) begin
      pend_q.delete();
      m_addr = '0; m_data = '0; m_data_g = '0; m_cnt = '0;
    end else if (v && exp_ready) begin
      p.due   = cyc + 3;
      p.key   = {s, a};
      p.learn = learn;
      p.res_a = ref_update(GAMMA_A, SHIFT_A, r, q, qm);
      p.res_b = ref_update(GAMMA_B, SHIFT_B, r, q, qm);
      pend_q.push_back(p);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, acc);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic        acc;
    logic [31:0] cnt_snap;
    logic        rv, rl, rr;
    logic [11:0] rs;
    logic [1:0]  ra;

    rst = 1'b1; in_valid = 1'b0; learning = 1'b0; in_state = '0; in_action = '0;
    in_reward = '0; in_q_sa = '0; in_q_max_next = '0;
    cyc = 0; m_addr = '0; m_data = '0; m_data_g = '0; m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_wr_en",   64'(wr_en),    64'd0);
    check("rst_wr_addr", 64'(wr_addr),  64'd0);
    check("rst_wr_data", 64'(wr_data),  64'd0);
    check("rst_sat",     64'(sat_flag), 64'd0);
    check("rst_upd_cnt", 64'(upd_cnt),  64'd0);
    check("rst_ready",   64'(in_ready), 64'd1);

    // 1: basic update, three-cycle latency.
    step(1'b1, 12'd5, 2'd2, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("t1_accept", 64'(acc), 64'd1);
    idle(2);
    check("t1_wr_en",    64'(wr_en),    64'd1);
    check("t1_wr_addr",  64'(wr_addr),  64'h016);
    check("t1_wr_data",  64'(wr_data),  64'h0000_2000);
    check("t1_sat",      64'(sat_flag), 64'd0);
    check("t1_upd_cnt",  64'(upd_cnt),  64'd1);
    idle(1);

    // 2: GAMMA=0x8000 instance, td becomes zero.
    step(1'b1, 12'd7, 2'd1, 32'h0, 32'h0001_0000, 32'h0002_0000, 1'b1, 1'b0, acc);
    idle(2);
    check("t2_wr_en_g",   64'(wr_en_g),   64'd1);
    check("t2_wr_data_g", 64'(wr_data_g), 64'h0001_0000);
    idle(1);

    // 3: positive saturation, one-cycle sat pulse.
    step(1'b1, 12'd8, 2'd0, 32'h7FFF_FFFF, 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, acc);
    idle(2);
    check("t3_wr_data", 64'(wr_data),  64'h7FFF_FFFF);
    check("t3_sat",     64'(sat_flag), 64'd1);
    idle(1);
    check("t3_sat_end", 64'(sat_flag), 64'd0);

    // 4: floor rounding of a negative td.
    step(1'b1, 12'd9, 2'd3, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    idle(2);
    check("t4_wr_data", 64'(wr_data), 64'hFFFF_FFFF);
    idle(1);

    // 5a: same key held off for three cycles, accepted at N+4, written at N+7.
    step(1'b1, 12'd20, 2'd1, 32'h0000_4000, 32'h0000_1000, 32'h0, 1'b1, 1'b0, acc);
    check("t5_first_accept", 64'(acc), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 12'd20, 2'd1, 32'h0000_8000, 32'h0000_1000, 32'h0, 1'b1, 1'b0, acc);
      check("t5_blocked", 64'(acc), 64'd0);
    end
    step(1'b1, 12'd20, 2'd1, 32'h0000_8000, 32'h0000_1000, 32'h0, 1'b1, 1'b0, acc);
    check("t5_retry_accept", 64'(acc), 64'd1);
    idle(2);
    check("t5_second_wr_en",   64'(wr_en),   64'd1);
    check("t5_second_wr_addr", 64'(wr_addr), 64'h051);
    idle(1);

    // 5b: a different key right behind is accepted at once and writes at N+4.
    step(1'b1, 12'd21, 2'd0, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b1, 12'd22, 2'd3, 32'h0002_0000, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("t5_distinct_accept", 64'(acc), 64'd1);
    idle(2);
    check("t5_distinct_wr_addr", 64'(wr_addr), 64'h05B);
    idle(1);

    // 6a: learning=0 discards the write and leaves the counter alone.
    cnt_snap = m_cnt;
    step(1'b1, 12'd30, 2'd0, 32'h0003_0000, 32'h0, 32'h0, 1'b0, 1'b0, acc);
    idle(2);
    check("t6_no_wr_en",   64'(wr_en),   64'd0);
    check("t6_cnt_steady", 64'(upd_cnt), 64'(cnt_snap));
    idle(1);

    // 6b: learning sampled at transfer; later drops of the input do not matter.
    step(1'b1, 12'd31, 2'd2, 32'h0003_0000, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    idle(2);
    check("t6_learn_travels", 64'(wr_en), 64'd1);
    idle(1);

    // 6c: reset one cycle after transfer drops the update; same key accepted right after.
    step(1'b1, 12'd32, 2'd1, 32'h0005_0000, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, acc);
    step(1'b1, 12'd32, 2'd1, 32'h0006_0000, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    check("t6_ready_after_rst", 64'(acc), 64'd1);
    check("t6_dropped_wr_en",   64'(wr_en), 64'd0);
    idle(3);

    // Random traffic over a small key space so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(0, 9) < 7);
      rs = 12'($urandom_range(0, 3));
      ra = 2'($urandom_range(0, 3));
      rl = ($urandom_range(0, 9) != 0);
      rr = ($urandom_range(0, 199) == 0);
      step(rv & ~rr, rs, ra, rnd32(), rnd32(), rnd32(), rl, rr, acc);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
